// File: rtl/fir_mac_scheduler.sv
// Multi-channel FIR filter sharing one MAC: decimated triggers stage samples, a round-robin
// scheduler grants one channel at a time for an N-cycle multiply-accumulate pass.
module fir_mac_scheduler #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned N          = 32,
  parameter int unsigned WIDTH      = 14,
  parameter int          DIV_FACTOR = 4,
  parameter int unsigned SHIFT      = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NCH-1:0]         i_trig,
  input  logic [NCH*WIDTH-1:0]   din,
  input  logic                   coef_we,
  input  logic [$clog2(N)-1:0]   coef_addr,
  input  logic [15:0]            coef_data,
  input  logic                   clr_flags,
  output logic [NCH*32-1:0]      dout,
  output logic [NCH-1:0]         dout_valid,
  output logic                   busy,
  output logic [NCH-1:0]         overrun,
  output logic                   coef_err
);

  localparam int          DivEff = (DIV_FACTOR > 1) ? DIV_FACTOR : 1;
  localparam int unsigned CW     = (DivEff > 1) ? $clog2(DivEff) : 1;
  localparam int unsigned IW     = $clog2(N);
  localparam int unsigned AW     = WIDTH + 16 + IW;
  localparam int unsigned CHW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DivEff - 1);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e state_q, state_d;

  logic [CW-1:0]             cnt_q   [NCH];
  logic signed [WIDTH-1:0]   stage_q [NCH];
  logic [NCH-1:0]            pend_q;
  logic signed [WIDTH-1:0]   taps_q  [NCH][N];
  logic signed [15:0]        coef_q  [N];
  logic signed [AW-1:0]      acc_q;
  logic [IW-1:0]             k_q;
  logic [CHW-1:0]            ch_q;
  logic [CHW-1:0]            last_q;
  logic [31:0]               dout_q  [NCH];
  logic [NCH-1:0]            valid_q;
  logic [NCH-1:0]            overrun_q, overrun_d;
  logic                      cerr_q, cerr_d;

  logic [NCH-1:0]            accept;
  logic                      grant_vld, grant;
  logic [CHW-1:0]            grant_ch;
  logic signed [AW-1:0]      prod;
  logic [31:0]               res;

  always_comb begin
    for (int c = 0; c < int'(NCH); c++) begin
      accept[c] = i_trig[c] && (cnt_q[c] == CntMax);
    end
  end

  // Round-robin search starting just after the last served channel.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int i = 1; i <= int'(NCH); i++) begin
      idx = (int'(last_q) + i) % int'(NCH);
      if (!grant_vld && pend_q[CHW'(idx)]) begin
        grant_vld = 1'b1;
        grant_ch  = CHW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_vld) state_d = StMac;
      StMac:   if (k_q == IW'(N - 1)) state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy  = (state_q != StIdle);
    grant = (state_q == StIdle) && grant_vld;
  end

  always_comb begin
    prod = AW'(coef_q[k_q]) * AW'(taps_q[ch_q][k_q]);
    res  = 32'((AW + 32)'(acc_q) >>> SHIFT);
  end

  // A set event in the same cycle wins over clr_flags.
  always_comb begin
    for (int c = 0; c < int'(NCH); c++) begin
      overrun_d[c] = (accept[c] && pend_q[c] && !(grant && (int'(grant_ch) == c)))
                     || (overrun_q[c] && !clr_flags);
    end
    cerr_d = (coef_we && busy) || (cerr_q && !clr_flags);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_q    <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      ch_q      <= '0;
      last_q    <= CHW'(NCH - 1);
      valid_q   <= '0;
      overrun_q <= '0;
      cerr_q    <= 1'b0;
      for (int k = 0; k < int'(N); k++) coef_q[k] <= '0;
      for (int c = 0; c < int'(NCH); c++) begin
        cnt_q[c]   <= '0;
        stage_q[c] <= '0;
        dout_q[c]  <= '0;
        for (int k = 0; k < int'(N); k++) taps_q[c][k] <= '0;
      end
    end else begin
      valid_q   <= '0;
      overrun_q <= overrun_d;
      cerr_q    <= cerr_d;

      if (coef_we && !busy) coef_q[coef_addr] <= coef_data;

      if (grant) begin
        for (int k = int'(N) - 1; k > 0; k--) taps_q[grant_ch][k] <= taps_q[grant_ch][k-1];
        taps_q[grant_ch][0] <= stage_q[grant_ch];
        pend_q[grant_ch]    <= 1'b0;
        acc_q               <= '0;
        k_q                 <= '0;
        ch_q                <= grant_ch;
      end

      if (state_q == StMac) begin
        acc_q <= acc_q + prod;
        k_q   <= k_q + IW'(1);
      end

      if (state_q == StOut) begin
        dout_q[ch_q]  <= res;
        valid_q[ch_q] <= 1'b1;
        last_q        <= ch_q;
      end

      // Placed after the grant so a same-edge accepted trigger keeps pend set.
      for (int c = 0; c < int'(NCH); c++) begin
        if (i_trig[c]) cnt_q[c] <= accept[c] ? '0 : cnt_q[c] + CW'(1);
        if (accept[c]) begin
          stage_q[c] <= din[c*WIDTH +: WIDTH];
          pend_q[c]  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < int'(NCH); c++) dout[c*32 +: 32] = dout_q[c];
    dout_valid = valid_q;
    overrun    = overrun_q;
    coef_err   = cerr_q;
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Randomized bench for fir_mac_scheduler against a transaction-level scheduler/FIR model.
module tb_fir_mac_scheduler;

  localparam int NCH   = 4;
  localparam int N     = 8;
  localparam int WIDTH = 14;
  localparam int DIV   = 2;
  localparam int SHIFT = 3;

  logic                 clk = 1'b0;
  logic                 n_rst = 1'b0;
  logic [NCH-1:0]       i_trig = '0;
  logic [NCH*WIDTH-1:0] din = '0;
  logic                 coef_we = 1'b0;
  logic [2:0]           coef_addr = '0;
  logic [15:0]          coef_data = '0;
  logic                 clr_flags = 1'b0;
  logic [NCH*32-1:0]    dout;
  logic [NCH-1:0]       dout_valid;
  logic                 busy;
  logic [NCH-1:0]       overrun;
  logic                 coef_err;

  always #5 clk = ~clk;

  fir_mac_scheduler #(
    .NCH(NCH), .N(N), .WIDTH(WIDTH), .DIV_FACTOR(DIV), .SHIFT(SHIFT)
  ) u_dut (
    .clk(clk), .n_rst(n_rst), .i_trig(i_trig), .din(din), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .clr_flags(clr_flags), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .overrun(overrun), .coef_err(coef_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  int             m_cnt   [NCH];
  bit             m_pend  [NCH];
  int             m_stage [NCH];
  int             m_hist  [NCH][N];
  int             m_coef  [N];
  logic [31:0]    m_dout  [NCH];
  int             m_last;
  int             m_busy;
  bit [NCH-1:0]   m_ovr;
  bit             m_cerr;
  bit [NCH-1:0]   m_vld;
  bit             r_pend;
  int             r_ch;
  logic [31:0]    r_val;
  longint         r_due;
  longint         edges;

  // Stimulus for the current cycle.
  bit [NCH-1:0]   s_trig;
  int             s_din [NCH];
  bit             s_we;
  int             s_addr;
  int             s_cdata;
  bit             s_clr;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_pend[c] = 0; m_stage[c] = 0; m_dout[c] = '0;
      for (int k = 0; k < N; k++) m_hist[c][k] = 0;
    end
    for (int k = 0; k < N; k++) m_coef[k] = 0;
    m_last = NCH - 1; m_busy = 0; m_ovr = '0; m_cerr = 0; m_vld = '0; r_pend = 0;
  endtask

  task automatic model_edge();
    bit     was_busy;
    int     g;
    longint acc;
    edges++;
    was_busy = (m_busy > 0);
    if (m_busy > 0) m_busy--;
    m_vld = '0;
    if (r_pend && edges == r_due) begin
      m_dout[r_ch] = r_val;
      m_vld[r_ch]  = 1'b1;
      r_pend       = 0;
    end
    if (s_clr) begin
      m_ovr  = '0;
      m_cerr = 0;
    end
    if (s_we) begin
      if (!was_busy) m_coef[s_addr] = s_cdata;
      else           m_cerr = 1;
    end
    g = -1;
    if (!was_busy) begin
      for (int i = 1; i <= NCH; i++) begin
        if (g < 0 && m_pend[(m_last + i) % NCH]) g = (m_last + i) % NCH;
      end
    end
    if (g >= 0) begin
      for (int k = N - 1; k > 0; k--) m_hist[g][k] = m_hist[g][k-1];
      m_hist[g][0] = m_stage[g];
      m_pend[g] = 0;
      acc = 0;
      for (int k = 0; k < N; k++) acc += longint'(m_coef[k]) * longint'(m_hist[g][k]);
      r_val  = 32'(acc >>> SHIFT);
      r_ch   = g;
      r_due  = edges + N + 1;
      r_pend = 1;
      m_last = g;
      m_busy = N + 1;
    end
    for (int c = 0; c < NCH; c++) begin
      if (s_trig[c]) begin
        if (DIV <= 1 || m_cnt[c] == DIV - 1) begin
          m_cnt[c] = 0;
          if (m_pend[c] && g != c) m_ovr[c] = 1'b1;
          m_stage[c] = s_din[c];
          m_pend[c]  = 1;
        end else begin
          m_cnt[c]++;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [127:0] pk;
    pk = '0;
    for (int c = 0; c < NCH; c++) pk[c*32 +: 32] = m_dout[c];
    check_eq("dout", dout, pk);
    check_eq("dout_valid", dout_valid, m_vld);
    check_eq("busy", busy, m_busy > 0);
    check_eq("overrun", overrun, m_ovr);
    check_eq("coef_err", coef_err, m_cerr);
  endtask

  task automatic drive_idle();
    s_trig = '0; s_we = 0; s_clr = 0; s_addr = 0; s_cdata = 0;
    for (int c = 0; c < NCH; c++) s_din[c] = 0;
    i_trig = '0; din = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0; clr_flags = 1'b0;
  endtask

  task automatic step(input int trig_rate, input int we_rate);
    for (int c = 0; c < NCH; c++) begin
      s_trig[c] = ($urandom_range(trig_rate - 1, 0) == 0);
      s_din[c]  = int'($urandom_range(16383, 0)) - 8192;
      din[c*WIDTH +: WIDTH] = s_din[c][WIDTH-1:0];
    end
    s_we    = ($urandom_range(we_rate - 1, 0) == 0);
    s_addr  = int'($urandom_range(N - 1, 0));
    s_cdata = int'($urandom_range(65535, 0)) - 32768;
    s_clr   = ($urandom_range(31, 0) == 0);
    i_trig    = s_trig;
    coef_we   = s_we;
    coef_addr = s_addr[2:0];
    coef_data = s_cdata[15:0];
    clr_flags = s_clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    edges = 0;
    model_reset();
    drive_idle();
    repeat (3) @(negedge clk);
    check_outputs();
    n_rst = 1'b1;

    for (int i = 0; i < 300; i++) step(60, 3);
    for (int i = 0; i < 800; i++) step(4, 8);
    for (int i = 0; i < 400; i++) step(12, 5);

    // Abort a computation halfway through the MAC pass.
    for (int i = 0; i < 400 && m_busy != N / 2; i++) step(4, 50);
    check_eq("mid_mac_busy", busy, 1'b1);
    drive_idle();
    n_rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(negedge clk);
    check_outputs();
    n_rst = 1'b1;

    for (int i = 0; i < 300; i++) step(40, 3);
    for (int i = 0; i < 500; i++) step(5, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
